// File: rtl/vga_fb_pkg.sv
// -----------------------------------------------------------------------------
// vga_fb_pkg
// Shared definitions for the framebuffer arbiter slice: framebuffer geometry,
// bus widths, the slot grant encoding, the host round-robin pointer encoding
// and the address range check used on every host transaction.
// No ports (package).
// -----------------------------------------------------------------------------
package vga_fb_pkg;

   localparam int FB_W    = 200;
   localparam int FB_H    = 150;
   localparam int ADDR_W  = 15;
   localparam int DATA_W  = 6;
   localparam int FB_SIZE = FB_W * FB_H;

   // Owner of the current RAM command slot
   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_DISP = 2'd1,
      GNT_WR   = 2'd2,
      GNT_RD   = 2'd3
   } gnt_e;

   // Host channel favoured when both holding registers are full
   typedef enum logic {
      RR_WR = 1'b0,
      RR_RD = 1'b1
   } rr_e;

   // True when the address lies inside the visible framebuffer
   function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
      return (32'(addr) < 32'(FB_SIZE));
   endfunction

endpackage

// File: rtl/vga_fb_hold_reg.sv
// -----------------------------------------------------------------------------
// vga_fb_hold_reg
// One-entry valid/ready holding register. Accepts a payload when empty,
// presents it with a full flag, and empties when the arbiter grants it.
// Ports:
//   i_clk, i_rst  clock and synchronous active-high reset
//   i_valid       upstream valid
//   o_ready       upstream ready (register empty)
//   i_payload     upstream payload
//   i_grant       arbiter grant; empties the register
//   o_full        register holds a pending transaction
//   o_payload     held payload
// -----------------------------------------------------------------------------
module vga_fb_hold_reg #(
   parameter int PAYLOAD_W = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [PAYLOAD_W-1:0] i_payload,
   input  logic                 i_grant,
   output logic                 o_full,
   output logic [PAYLOAD_W-1:0] o_payload
);

   logic                 full_q;
   logic                 full_d;
   logic [PAYLOAD_W-1:0] payload_q;
   logic [PAYLOAD_W-1:0] payload_d;

   // Next-state: load when empty, drain on grant (never both in one cycle)
   always_comb begin
      full_d    = full_q;
      payload_d = payload_q;
      if (i_valid && !full_q) begin
         full_d    = 1'b1;
         payload_d = i_payload;
      end else if (i_grant) begin
         full_d    = 1'b0;
      end else begin
         full_d    = full_q;
      end
   end

   // State register with synchronous reset
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         full_q    <= 1'b0;
         payload_q <= {PAYLOAD_W{1'b0}};
      end else begin
         full_q    <= full_d;
         payload_q <= payload_d;
      end
   end

   assign o_ready   = !full_q;
   assign o_full    = full_q;
   assign o_payload = payload_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// -----------------------------------------------------------------------------
// vga_fb_arbiter
// Shares one single-port framebuffer RAM between the display scanout fetch
// (absolute priority, fixed 3-cycle latency) and a host write/read port.
// Host traffic fills idle slots, alternating between write and read when both
// are pending.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_disp_req/i_disp_addr       display fetch request
//   o_disp_valid/o_disp_data     display pixel, 3 cycles after the request
//   i_wr_valid/o_wr_ready        host write handshake (i_wr_addr, i_wr_data)
//   i_rd_valid/o_rd_ready        host read handshake (i_rd_addr)
//   o_rd_valid/o_rd_data         host read data, 2 cycles after the grant
//   o_mem_en/we/addr/wdata       RAM command
//   i_mem_rdata                  RAM data, one cycle after a read command
//   o_err                        sticky out-of-range host address
//   o_starve                     sticky host starvation
// -----------------------------------------------------------------------------
module vga_fb_arbiter
   import vga_fb_pkg::*;
#(
   parameter int STARVE_LIMIT = 1023
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_disp_req,
   input  logic [ADDR_W-1:0] i_disp_addr,
   output logic              o_disp_valid,
   output logic [DATA_W-1:0] o_disp_data,
   input  logic              i_wr_valid,
   output logic              o_wr_ready,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_rd_valid,
   output logic              o_rd_ready,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic              o_rd_valid,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_err,
   output logic              o_starve
);

   localparam int               CNT_W      = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
   localparam int               WR_PAY_W   = ADDR_W + DATA_W;

   // Display request stage
   logic              disp_req_q,  disp_req_d;
   logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;

   // Read-data pipeline and registered outputs
   logic              disp_p_q,     disp_p_d;
   logic              rd_p_q,       rd_p_d;
   logic              rd_oor_p_q,   rd_oor_p_d;
   logic              disp_valid_q, disp_valid_d;
   logic [DATA_W-1:0] disp_data_q,  disp_data_d;
   logic              rd_valid_q,   rd_valid_d;
   logic [DATA_W-1:0] rd_data_q,    rd_data_d;

   // Arbitration and status state
   rr_e               rr_q,     rr_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic              err_q,    err_d;
   logic              starve_q, starve_d;

   // Holding register interfaces
   logic                wr_ready_s, wr_full_s, wr_gnt_s;
   logic [WR_PAY_W-1:0] wr_pay_s;
   logic [ADDR_W-1:0]   wr_addr_s;
   logic [DATA_W-1:0]   wr_data_s;
   logic                rd_ready_s, rd_full_s, rd_gnt_s;
   logic [ADDR_W-1:0]   rd_addr_s;

   // Slot decision and RAM command
   gnt_e              gnt_s;
   logic              mem_en_s;
   logic              mem_we_s;
   logic [ADDR_W-1:0] mem_addr_s;
   logic [DATA_W-1:0] mem_wdata_s;

   vga_fb_hold_reg #(
      .PAYLOAD_W (WR_PAY_W)
   ) u_wr_hold (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_valid   (i_wr_valid),
      .o_ready   (wr_ready_s),
      .i_payload ({i_wr_addr, i_wr_data}),
      .i_grant   (wr_gnt_s),
      .o_full    (wr_full_s),
      .o_payload (wr_pay_s)
   );

   vga_fb_hold_reg #(
      .PAYLOAD_W (ADDR_W)
   ) u_rd_hold (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_valid   (i_rd_valid),
      .o_ready   (rd_ready_s),
      .i_payload (i_rd_addr),
      .i_grant   (rd_gnt_s),
      .o_full    (rd_full_s),
      .o_payload (rd_addr_s)
   );

   assign wr_addr_s = wr_pay_s[WR_PAY_W-1:DATA_W];
   assign wr_data_s = wr_pay_s[DATA_W-1:0];

   // Slot owner: a display request registered last cycle always takes it
   always_comb begin
      gnt_s = GNT_NONE;
      if (disp_req_q) begin
         gnt_s = GNT_DISP;
      end else if (wr_full_s && rd_full_s) begin
         gnt_s = (rr_q == RR_WR) ? GNT_WR : GNT_RD;
      end else if (wr_full_s) begin
         gnt_s = GNT_WR;
      end else if (rd_full_s) begin
         gnt_s = GNT_RD;
      end else begin
         gnt_s = GNT_NONE;
      end
   end

   assign wr_gnt_s = (gnt_s == GNT_WR);
   assign rd_gnt_s = (gnt_s == GNT_RD);

   // RAM command for the slot; out-of-range host slots issue nothing
   always_comb begin
      mem_en_s    = 1'b0;
      mem_we_s    = 1'b0;
      mem_addr_s  = {ADDR_W{1'b0}};
      mem_wdata_s = {DATA_W{1'b0}};
      case (gnt_s)
         GNT_DISP: begin
            mem_en_s   = 1'b1;
            mem_addr_s = disp_addr_q;
         end
         GNT_WR: begin
            if (addr_in_range(wr_addr_s)) begin
               mem_en_s    = 1'b1;
               mem_we_s    = 1'b1;
               mem_addr_s  = wr_addr_s;
               mem_wdata_s = wr_data_s;
            end else begin
               mem_en_s    = 1'b0;
            end
         end
         GNT_RD: begin
            if (addr_in_range(rd_addr_s)) begin
               mem_en_s   = 1'b1;
               mem_addr_s = rd_addr_s;
            end else begin
               mem_en_s   = 1'b0;
            end
         end
         default: begin
            mem_en_s = 1'b0;
         end
      endcase
   end

   // Next-state for pipelines, round-robin pointer, starvation and error flags
   always_comb begin
      disp_req_d   = i_disp_req;
      disp_addr_d  = i_disp_addr;
      disp_p_d     = (gnt_s == GNT_DISP);
      rd_p_d       = rd_gnt_s;
      rd_oor_p_d   = rd_gnt_s && !addr_in_range(rd_addr_s);
      disp_valid_d = disp_p_q;
      disp_data_d  = disp_p_q ? i_mem_rdata : {DATA_W{1'b0}};
      rd_valid_d   = rd_p_q;
      // An out-of-range read had no RAM command, so whatever is on the bus is stale
      rd_data_d    = (rd_p_q && !rd_oor_p_q) ? i_mem_rdata : {DATA_W{1'b0}};

      rr_d = rr_q;
      if (wr_gnt_s) begin
         rr_d = RR_RD;
      end else if (rd_gnt_s) begin
         rr_d = RR_WR;
      end else begin
         rr_d = rr_q;
      end

      cnt_d = cnt_q;
      if (wr_gnt_s || rd_gnt_s) begin
         cnt_d = {CNT_W{1'b0}};
      end else if ((wr_full_s || rd_full_s) && (cnt_q != STARVE_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
      starve_d = starve_q || (cnt_d == STARVE_MAX);

      // Flag the address at acceptance time
      err_d = err_q
            || (i_wr_valid && wr_ready_s && !addr_in_range(i_wr_addr))
            || (i_rd_valid && rd_ready_s && !addr_in_range(i_rd_addr));
   end

   // State registers with synchronous reset; in-flight strobes are discarded
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         disp_req_q   <= 1'b0;
         disp_addr_q  <= {ADDR_W{1'b0}};
         disp_p_q     <= 1'b0;
         rd_p_q       <= 1'b0;
         rd_oor_p_q   <= 1'b0;
         disp_valid_q <= 1'b0;
         disp_data_q  <= {DATA_W{1'b0}};
         rd_valid_q   <= 1'b0;
         rd_data_q    <= {DATA_W{1'b0}};
         rr_q         <= RR_WR;
         cnt_q        <= {CNT_W{1'b0}};
         err_q        <= 1'b0;
         starve_q     <= 1'b0;
      end else begin
         disp_req_q   <= disp_req_d;
         disp_addr_q  <= disp_addr_d;
         disp_p_q     <= disp_p_d;
         rd_p_q       <= rd_p_d;
         rd_oor_p_q   <= rd_oor_p_d;
         disp_valid_q <= disp_valid_d;
         disp_data_q  <= disp_data_d;
         rd_valid_q   <= rd_valid_d;
         rd_data_q    <= rd_data_d;
         rr_q         <= rr_d;
         cnt_q        <= cnt_d;
         err_q        <= err_d;
         starve_q     <= starve_d;
      end
   end

   assign o_disp_valid = disp_valid_q;
   assign o_disp_data  = disp_data_q;
   assign o_wr_ready   = wr_ready_s;
   assign o_rd_ready   = rd_ready_s;
   assign o_rd_valid   = rd_valid_q;
   assign o_rd_data    = rd_data_q;
   assign o_mem_en     = mem_en_s;
   assign o_mem_we     = mem_we_s;
   assign o_mem_addr   = mem_addr_s;
   assign o_mem_wdata  = mem_wdata_s;
   assign o_err        = err_q;
   assign o_starve     = starve_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vga_fb_arbiter
// Directed bench for vga_fb_arbiter with a behavioural single-port RAM
// (one-cycle read latency). Inputs change and outputs are sampled 1 time unit
// after each rising edge.
// -----------------------------------------------------------------------------
module tb_vga_fb_arbiter;
   import vga_fb_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              disp_req;
   logic [ADDR_W-1:0] disp_addr;
   logic              disp_valid;
   logic [DATA_W-1:0] disp_data;
   logic              wr_valid, wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              rd_valid, rd_ready;
   logic [ADDR_W-1:0] rd_addr;
   logic              rdv;
   logic [DATA_W-1:0] rdd;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              err, starve;

   logic              pl_en;
   logic [ADDR_W-1:0] pl_addr;
   logic [DATA_W-1:0] pl_data;
   logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   vga_fb_arbiter #(.STARVE_LIMIT(8)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_disp_req  (disp_req),
      .i_disp_addr (disp_addr),
      .o_disp_valid(disp_valid),
      .o_disp_data (disp_data),
      .i_wr_valid  (wr_valid),
      .o_wr_ready  (wr_ready),
      .i_wr_addr   (wr_addr),
      .i_wr_data   (wr_data),
      .i_rd_valid  (rd_valid),
      .o_rd_ready  (rd_ready),
      .i_rd_addr   (rd_addr),
      .o_rd_valid  (rdv),
      .o_rd_data   (rdd),
      .o_mem_en    (mem_en),
      .o_mem_we    (mem_we),
      .o_mem_addr  (mem_addr),
      .o_mem_wdata (mem_wdata),
      .i_mem_rdata (mem_rdata),
      .o_err       (err),
      .o_starve    (starve)
   );

   // Behavioural RAM with a bench-side preload port
   always @(posedge clk) begin
      if (pl_en) ram[pl_addr] <= pl_data;
      else if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_out"}, {disp_valid, disp_data, rdv, rdd, mem_en, mem_we,
                          mem_addr, mem_wdata, err, starve}, 64'd0);
      chk({tag, "_rdy"}, {wr_ready, rd_ready}, 64'd3);
   endtask

   initial begin
      int strobes;
      int disp_cmds;
      int we_seen;

      rst = 1'b1; disp_req = 1'b0; disp_addr = '0;
      wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      rd_valid = 1'b0; rd_addr = '0;
      pl_en = 1'b0; pl_addr = '0; pl_data = '0;
      tick(); tick();
      chk_idle("reset");
      rst = 1'b0;

      pl_en = 1'b1; pl_addr = 15'd5; pl_data = 6'h2A; tick();
      pl_addr = 15'd7; pl_data = 6'h11; tick();
      pl_en = 1'b0;

      // Single display fetch: command next cycle, strobe 3 cycles after request
      disp_req = 1'b1; disp_addr = 15'd5;
      tick();
      disp_req = 1'b0;
      chk("disp_cmd", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 15'd5});
      chk("disp_early1", disp_valid, 64'd0);
      tick();
      chk("disp_early2", disp_valid, 64'd0);
      tick();
      chk("disp_valid", {disp_valid, disp_data}, {1'b1, 6'h2A});
      tick();
      chk("disp_off", disp_valid, 64'd0);

      // Back-to-back display fetches
      disp_req = 1'b1; disp_addr = 15'd5;
      tick();
      disp_addr = 15'd7;
      tick();
      disp_req = 1'b0;
      tick();
      chk("b2b_first", {disp_valid, disp_data}, {1'b1, 6'h2A});
      tick();
      chk("b2b_second", {disp_valid, disp_data}, {1'b1, 6'h11});
      tick();
      chk("b2b_off", disp_valid, 64'd0);

      // Host write then read of the same address
      chk("wr_ready_idle", wr_ready, 64'd1);
      wr_valid = 1'b1; wr_addr = 15'd100; wr_data = 6'h15;
      tick();
      wr_valid = 1'b0;
      chk("wr_cmd", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 15'd100, 6'h15});
      chk("wr_ready_busy", wr_ready, 64'd0);
      tick();
      chk("wr_ready_back", {wr_ready, mem_en}, {1'b1, 1'b0});
      rd_valid = 1'b1; rd_addr = 15'd100;
      tick();
      rd_valid = 1'b0;
      chk("rd_cmd", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 15'd100});
      chk("rd_ready_busy", rd_ready, 64'd0);
      tick();
      chk("rd_early", rdv, 64'd0);
      tick();
      chk("rd_data", {rdv, rdd}, {1'b1, 6'h15});
      tick();
      chk("rd_off_err", {rdv, err}, 64'd0);

      // Contention: 20 display requests with a write and a read pending
      strobes = 0; disp_cmds = 0;
      disp_req = 1'b1; disp_addr = 15'd5;
      wr_valid = 1'b1; wr_addr = 15'd200; wr_data = 6'h3C;
      rd_valid = 1'b1; rd_addr = 15'd100;
      for (int i = 1; i <= 25; i++) begin
         tick();
         if (i == 1) begin
            wr_valid = 1'b0;
            rd_valid = 1'b0;
         end
         if (disp_valid && disp_data == 6'h2A) strobes++;
         if (i <= 20 && mem_en && !mem_we && mem_addr == 15'd5) disp_cmds++;
         if (i == 20) disp_req = 1'b0;
         if (i == 21) chk("cont_wr_first", {mem_en, mem_we, mem_addr, mem_wdata},
                          {1'b1, 1'b1, 15'd200, 6'h3C});
         if (i == 22) chk("cont_rd_next", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 15'd100});
         if (i == 24) chk("cont_rd_data", {rdv, rdd}, {1'b1, 6'h15});
      end
      chk("cont_strobes", strobes, 64'd20);
      chk("cont_disp_slots", disp_cmds, 64'd20);
      chk("cont_starved", starve, 64'd1);

      // Reset clears sticky flags
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_idle("reset2");

      // Starvation with limit 8
      disp_req = 1'b1; disp_addr = 15'd5;
      wr_valid = 1'b1; wr_addr = 15'd300; wr_data = 6'h01;
      for (int i = 1; i <= 14; i++) begin
         tick();
         if (i == 1) wr_valid = 1'b0;
         if (i == 8) chk("starve_before", starve, 64'd0);
         if (i == 9) chk("starve_set", starve, 64'd1);
         if (i == 11) disp_req = 1'b0;
         if (i == 12) chk("starve_wr_cmd", {mem_en, mem_we, mem_addr, mem_wdata},
                          {1'b1, 1'b1, 15'd300, 6'h01});
         if (i == 14) chk("starve_sticky", starve, 64'd1);
      end

      // Out-of-range host accesses
      chk("oor_err_clear", err, 64'd0);
      we_seen = 0;
      wr_valid = 1'b1; wr_addr = 15'd30000; wr_data = 6'h3F;
      tick();
      wr_valid = 1'b0;
      if (mem_we) we_seen++;
      chk("oor_wr_nocmd", {mem_en, mem_we}, 64'd0);
      chk("oor_err_set", err, 64'd1);
      tick();
      if (mem_we) we_seen++;
      chk("oor_wr_ready", wr_ready, 64'd1);
      rd_valid = 1'b1; rd_addr = 15'd30001;
      tick();
      rd_valid = 1'b0;
      if (mem_we) we_seen++;
      chk("oor_rd_nocmd", mem_en, 64'd0);
      chk("oor_no_we", we_seen, 64'd0);
      tick();
      chk("oor_rd_early", rdv, 64'd0);
      tick();
      chk("oor_rd_zero", {rdv, rdd}, {1'b1, 6'h00});
      tick();

      // Reset in the cycle after a read grant discards everything in flight
      rd_valid = 1'b1; rd_addr = 15'd100;
      tick();
      rd_valid = 1'b0;
      chk("rst_rd_cmd", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 15'd100});
      disp_req = 1'b1; disp_addr = 15'd5;
      wr_valid = 1'b1; wr_addr = 15'd101; wr_data = 6'h02;
      tick();
      disp_req = 1'b0; wr_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_idle("rst_mid");
      tick();
      chk("rst_no_late", {disp_valid, rdv, mem_en}, 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
